// File: rtl/opl2_timers.sv
// opl2_timers: the two OPL2 interval timers.
// Timer 1 ticks every TIMER1_DIV samples and Timer 2 every TIMER2_DIV samples.
// The block decodes host register writes to 0x02, 0x03 and 0x04.
// It returns the status byte {IRQ, FT1, FT2, 5'b0} and a registered active-low IRQ.
// Optional feature: when the macro OPL2_TIMERS_FORCE_OVERFLOW_EN is defined,
// force_timer_overflow makes every running timer overflow immediately.
module opl2_timers #(
   parameter int unsigned TIMER1_DIV = 4,
   parameter int unsigned TIMER2_DIV = 16
) (
   input  logic       clk,
   input  logic       ic_n,
   input  logic       sample_clk_en,
   input  logic       reg_wr_valid,
   input  logic [7:0] reg_wr_address,
   input  logic [7:0] reg_wr_data,
   input  logic       force_timer_overflow,
   output logic [7:0] status,
   output logic       irq_n
);

   localparam int unsigned P1W = (TIMER1_DIV > 1) ? $clog2(TIMER1_DIV) : 1;
   localparam int unsigned P2W = (TIMER2_DIV > 1) ? $clog2(TIMER2_DIV) : 1;
   localparam logic [P1W-1:0] P1_LAST = P1W'(TIMER1_DIV - 1);
   localparam logic [P2W-1:0] P2_LAST = P2W'(TIMER2_DIV - 1);

   logic [P1W-1:0] psc1_q, psc1_d;
   logic [P2W-1:0] psc2_q, psc2_d;
   logic [7:0]     pre1_q, pre1_d, pre2_q, pre2_d;
   logic [7:0]     cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic           st1_q, st1_d, st2_q, st2_d;
   logic           mask1_q, mask1_d, mask2_q, mask2_d;
   logic           ft1_q, ft1_d, ft2_q, ft2_d;
   logic           irq_n_q, irq_n_d;

   logic           wr_ctl, irq_rst, wr_flags;
   logic           start1, start2, tick1, tick2;
   logic           ovf1, ovf2, force1, force2;

   // Host write decode and timer tick strobes
   always_comb begin
      wr_ctl   = reg_wr_valid && (reg_wr_address == 8'h04);
      irq_rst  = wr_ctl && reg_wr_data[7];
      wr_flags = wr_ctl && !reg_wr_data[7];
      start1   = wr_flags && reg_wr_data[0] && !st1_q;
      start2   = wr_flags && reg_wr_data[1] && !st2_q;
      tick1    = sample_clk_en && (psc1_q == P1_LAST);
      tick2    = sample_clk_en && (psc2_q == P2_LAST);
   end

`ifdef OPL2_TIMERS_FORCE_OVERFLOW_EN
   assign force1 = force_timer_overflow && st1_q;
   assign force2 = force_timer_overflow && st2_q;
`else
   logic force_unused;
   assign force_unused = force_timer_overflow;
   assign force1 = 1'b0;
   assign force2 = 1'b0;
`endif

   // Free-running prescalers, advanced once per output sample
   always_comb begin
      psc1_d = psc1_q;
      psc2_d = psc2_q;
      if (sample_clk_en) begin
         psc1_d = (psc1_q == P1_LAST) ? '0 : psc1_q + P1W'(1);
         psc2_d = (psc2_q == P2_LAST) ? '0 : psc2_q + P2W'(1);
      end
   end

   // Timer 1 counter: a start load beats a same-cycle tick; overflow reloads the preset
   always_comb begin
      cnt1_d = cnt1_q;
      ovf1   = 1'b0;
      if (start1) begin
         cnt1_d = pre1_q;
      end else if (st1_q && (tick1 || force1)) begin
         if (force1 || (cnt1_q == 8'hFF)) begin
            cnt1_d = pre1_q;
            ovf1   = 1'b1;
         end else begin
            cnt1_d = cnt1_q + 8'd1;
         end
      end
   end

   // Timer 2 counter: same rules as timer 1
   always_comb begin
      cnt2_d = cnt2_q;
      ovf2   = 1'b0;
      if (start2) begin
         cnt2_d = pre2_q;
      end else if (st2_q && (tick2 || force2)) begin
         if (force2 || (cnt2_q == 8'hFF)) begin
            cnt2_d = pre2_q;
            ovf2   = 1'b1;
         end else begin
            cnt2_d = cnt2_q + 8'd1;
         end
      end
   end

   // Presets, control bits and flags; an overflow beats a same-cycle IRQ reset
   always_comb begin
      pre1_d  = pre1_q;
      pre2_d  = pre2_q;
      st1_d   = st1_q;
      st2_d   = st2_q;
      mask1_d = mask1_q;
      mask2_d = mask2_q;
      if (reg_wr_valid && (reg_wr_address == 8'h02)) pre1_d = reg_wr_data;
      if (reg_wr_valid && (reg_wr_address == 8'h03)) pre2_d = reg_wr_data;
      if (wr_flags) begin
         mask1_d = reg_wr_data[6];
         mask2_d = reg_wr_data[5];
         st2_d   = reg_wr_data[1];
         st1_d   = reg_wr_data[0];
      end
      if (ovf1 && !mask1_q)  ft1_d = 1'b1;
      else if (irq_rst)      ft1_d = 1'b0;
      else                   ft1_d = ft1_q;
      if (ovf2 && !mask2_q)  ft2_d = 1'b1;
      else if (irq_rst)      ft2_d = 1'b0;
      else                   ft2_d = ft2_q;
      irq_n_d = !(ft1_q || ft2_q);
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge ic_n) begin
      if (!ic_n) begin
         psc1_q  <= '0;
         psc2_q  <= '0;
         pre1_q  <= '0;
         pre2_q  <= '0;
         cnt1_q  <= '0;
         cnt2_q  <= '0;
         st1_q   <= 1'b0;
         st2_q   <= 1'b0;
         mask1_q <= 1'b0;
         mask2_q <= 1'b0;
         ft1_q   <= 1'b0;
         ft2_q   <= 1'b0;
         irq_n_q <= 1'b1;
      end else begin
         psc1_q  <= psc1_d;
         psc2_q  <= psc2_d;
         pre1_q  <= pre1_d;
         pre2_q  <= pre2_d;
         cnt1_q  <= cnt1_d;
         cnt2_q  <= cnt2_d;
         st1_q   <= st1_d;
         st2_q   <= st2_d;
         mask1_q <= mask1_d;
         mask2_q <= mask2_d;
         ft1_q   <= ft1_d;
         ft2_q   <= ft2_d;
         irq_n_q <= irq_n_d;
      end
   end

   assign status = {ft1_q || ft2_q, ft1_q, ft2_q, 5'b0_0000};
   assign irq_n  = irq_n_q;

endmodule

// File: tb/tb_opl2_timers.sv
// Bench for opl2_timers.
// A sample-counting model of both timers is checked against status and irq_n every cycle.
// Directed scenarios pin literal status values, IRQ latency and overflow timing.
module tb_opl2_timers;

   logic       clk = 1'b0;
   logic       ic_n = 1'b0;
   logic       sample_clk_en = 1'b0;
   logic       reg_wr_valid = 1'b0;
   logic [7:0] reg_wr_address = '0;
   logic [7:0] reg_wr_data = '0;
   logic       force_timer_overflow = 1'b0;
   logic [7:0] status;
   logic       irq_n;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

`ifdef OPL2_TIMERS_FORCE_OVERFLOW_EN
   localparam bit FORCE_EN = 1'b1;
`else
   localparam bit FORCE_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   opl2_timers #(.TIMER1_DIV(4), .TIMER2_DIV(16)) dut (
      .clk                  (clk),
      .ic_n                 (ic_n),
      .sample_clk_en        (sample_clk_en),
      .reg_wr_valid         (reg_wr_valid),
      .reg_wr_address       (reg_wr_address),
      .reg_wr_data          (reg_wr_data),
      .force_timer_overflow (force_timer_overflow),
      .status               (status),
      .irq_n                (irq_n)
   );

   // ---------------- behavioural model ----------------
   // Timer 0 is T1 (tick every 4th sample) and timer 1 is T2 (tick every 16th sample).
   int unsigned m_samples;
   int          m_cnt [2];
   int          m_pre [2];
   bit          m_st  [2];
   bit          m_mask[2];
   bit          m_ft  [2];
   bit          m_irq_n = 1'b1;
   int unsigned divs  [2] = '{4, 16};

   always @(posedge clk) begin
      if (!ic_n) begin
         m_samples = 0;
         m_irq_n   = 1'b1;
         for (int t = 0; t < 2; t++) begin
            m_cnt[t] = 0; m_pre[t] = 0; m_st[t] = 0; m_mask[t] = 0; m_ft[t] = 0;
         end
      end else begin
         bit ctl;
         bit clr;
         int unsigned samp_before;
         samp_before = m_samples;
         if (sample_clk_en) m_samples++;
         ctl = reg_wr_valid && (reg_wr_address == 8'h04);
         clr = ctl && reg_wr_data[7];
         m_irq_n = !(m_ft[0] || m_ft[1]);
         for (int t = 0; t < 2; t++) begin
            bit tick;
            bit starting;
            bit forced;
            bit ovf;
            tick     = sample_clk_en && ((samp_before % divs[t]) == divs[t] - 1);
            starting = ctl && !reg_wr_data[7] && reg_wr_data[t] && !m_st[t];
            forced   = FORCE_EN && force_timer_overflow && m_st[t];
            ovf      = 1'b0;
            if (starting) begin
               m_cnt[t] = m_pre[t];
            end else if (m_st[t] && (tick || forced)) begin
               if (forced || m_cnt[t] == 255) begin
                  m_cnt[t] = m_pre[t];
                  ovf = 1'b1;
               end else begin
                  m_cnt[t] = m_cnt[t] + 1;
               end
            end
            if (ovf && !m_mask[t]) m_ft[t] = 1'b1;
            else if (clr)          m_ft[t] = 1'b0;
         end
         if (reg_wr_valid && reg_wr_address == 8'h02) m_pre[0] = int'(reg_wr_data);
         if (reg_wr_valid && reg_wr_address == 8'h03) m_pre[1] = int'(reg_wr_data);
         if (ctl && !reg_wr_data[7]) begin
            m_st[0]   = reg_wr_data[0];
            m_st[1]   = reg_wr_data[1];
            m_mask[0] = reg_wr_data[6];
            m_mask[1] = reg_wr_data[5];
         end
      end
      #1;
      n_checks++;
      if (status !== {m_ft[0] || m_ft[1], m_ft[0], m_ft[1], 5'b0_0000}) begin
         n_errors++;
         $display("FAIL model_status t=%0t got=%h exp=%h", $time, status,
                  {m_ft[0] || m_ft[1], m_ft[0], m_ft[1], 5'b0_0000});
      end
      n_checks++;
      if (irq_n !== m_irq_n) begin
         n_errors++;
         $display("FAIL model_irq_n t=%0t got=%b exp=%b", $time, irq_n, m_irq_n);
      end
   end

   // ---------------- stimulus helpers ----------------
   int unsigned ccount = 0;
   int unsigned scount = 0;
   int unsigned se_period = 10;
   logic        drive_ic_n = 1'b0;

   task automatic step(input bit v, input logic [7:0] a, input logic [7:0] d, input bit f);
      @(negedge clk);
      ccount++;
      ic_n                 = drive_ic_n;
      sample_clk_en        = ((ccount % se_period) == 0);
      reg_wr_valid         = v;
      reg_wr_address       = a;
      reg_wr_data          = d;
      force_timer_overflow = f;
      if (!ic_n) scount = 0;
      else if (sample_clk_en) scount++;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) step(1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      step(1'b1, a, d, 1'b0);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Idles until status becomes nonzero, counting the sample pulses consumed before it did
   task automatic wait_flag(input string name, input int unsigned bound, output int unsigned samples);
      bit found = 1'b0;
      samples = 0;
      for (int unsigned i = 0; i < bound && !found; i++) begin
         step(1'b0, 8'h00, 8'h00, 1'b0);
         if (status != 8'h00) found = 1'b1;
         else if (sample_clk_en) samples++;
      end
      if (!found) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout got=status_%h exp=nonzero", name, status);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int unsigned s;
      int unsigned bound;

      // Reset held with random register traffic
      drive_ic_n = 1'b0;
      for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom_range(2, 4)), 8'($urandom), 1'b0);
      chk("reset_status", int'(status), 8'h00);
      chk("reset_irq_n", int'(irq_n), 1);
      drive_ic_n = 1'b1;
      idle(3);

      // Timer 1 from preset 0xFE: overflow on the 2nd tick
      wr(8'h02, 8'hFE);
      wr(8'h04, 8'h01);
      wait_flag("t1_wait", 200, s);
      chk("t1_status", int'(status), 8'hC0);
      chk("t1_irq_n_same_clk", int'(irq_n), 1);
      chk("t1_samples_5_to_8", int'(s >= 5 && s <= 8), 1);
      idle(1);
      chk("t1_irq_n_next_clk", int'(irq_n), 0);

      // Stop and clear flags
      wr(8'h04, 8'h00);
      wr(8'h04, 8'h80);
      idle(1);
      chk("clr1_status", int'(status), 8'h00);
      chk("clr1_irq_n_lag", int'(irq_n), 0);
      idle(1);
      chk("clr1_irq_n", int'(irq_n), 1);

      // Masked timer 1 with preset 0xFF keeps overflowing silently
      wr(8'h02, 8'hFF);
      wr(8'h04, 8'h41);
      idle(300);
      chk("mask_status", int'(status), 8'h00);
      chk("mask_irq_n", int'(irq_n), 1);
      wr(8'h04, 8'h00);
      idle(100);
      chk("unmask_no_retro", int'(status), 8'h00);

      // Unmasked timer 2 overflow, then IRQ reset
      wr(8'h03, 8'hFF);
      wr(8'h04, 8'h02);
      wait_flag("t2ff_wait", 400, s);
      chk("t2ff_status", int'(status), 8'hA0);
      wr(8'h04, 8'h00);
      wr(8'h04, 8'h80);
      idle(1);
      chk("clr2_status", int'(status), 8'h00);
      chk("clr2_irq_n_lag", int'(irq_n), 0);
      idle(1);
      chk("clr2_irq_n", int'(irq_n), 1);

      // Timer 2 full period from preset 0x00: 256 ticks of 16 samples
      se_period = 2;
      wr(8'h03, 8'h00);
      wr(8'h04, 8'h02);
      wait_flag("t2res_wait", 10000, s);
      chk("t2res_status", int'(status), 8'hA0);
      chk("t2res_samples_4081_to_4096", int'(s >= 4081 && s <= 4096), 1);
      wr(8'h04, 8'h00);
      wr(8'h04, 8'h80);
      idle(2);

      // Preset rewritten mid-count only matters at the next reload
      wr(8'h02, 8'hFE);
      wr(8'h04, 8'h01);
      wr(8'h02, 8'h80);
      wait_flag("preset_first_wait", 100, s);
      chk("preset_first_status", int'(status), 8'hC0);
      chk("preset_first_samples_4_to_8", int'(s >= 4 && s <= 8), 1);
      wr(8'h04, 8'h80);
      wait_flag("preset_reload_wait", 2000, s);
      chk("preset_reload_status", int'(status), 8'hC0);
      chk("preset_reload_samples_508_to_512", int'(s >= 508 && s <= 512), 1);
      wr(8'h04, 8'h00);
      wr(8'h04, 8'h80);
      idle(2);

      // IRQ reset write colliding with a timer 1 overflow tick
      se_period = 10;
      wr(8'h02, 8'hFF);
      wr(8'h04, 8'h41);
      bound = 0;
      while (!(((ccount + 2) % se_period == 0) && (scount % 4 == 3)) && bound < 500) begin
         idle(1);
         bound++;
      end
      chk("collision_setup_found", int'(bound < 500), 1);
      wr(8'h04, 8'h01);
      wr(8'h04, 8'h80);
      idle(1);
      chk("collision_status", int'(status), 8'hC0);
      wr(8'h04, 8'h00);
      wr(8'h04, 8'h80);
      idle(2);
      chk("collision_cleared", int'(status), 8'h00);

      // Force overflow: T1 running unmasked, T2 stopped
      wr(8'h02, 8'h10);
      wr(8'h04, 8'h01);
      idle(3);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      idle(1);
      chk("force_status", int'(status), FORCE_EN ? 8'hC0 : 8'h00);
      idle(1);
      chk("force_irq_n", int'(irq_n), FORCE_EN ? 0 : 1);
      wr(8'h04, 8'h80);
      se_period = 2;
      idle(2000);

      // Reset asserted mid-count
      drive_ic_n = 1'b0;
      idle(3);
      chk("midreset_status", int'(status), 8'h00);
      chk("midreset_irq_n", int'(irq_n), 1);
      drive_ic_n = 1'b1;
      idle(200);
      chk("post_reset_quiet", int'(status), 8'h00);
      chk("post_reset_irq_n", int'(irq_n), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/opl2_timers.md
Name: opl2_timers

Overview:
- Consumes the register-write stream from the host interface (address/data/valid) and implements the two OPL2 timers.
- Timer 1 has an 80 us resolution; Timer 2 has a 320 us resolution.
- Produces the 8-bit status byte returned on host reads, plus an active-low IRQ.
- Sits directly downstream of the host interface, in the opl3 clock domain.

Parameters:
- TIMER1_DIV, 4: sample_clk_en pulses per Timer 1 tick (80 us at 49.7 kHz).
- TIMER2_DIV, 16: sample_clk_en pulses per Timer 2 tick (320 us).

Ports:
- clk  in  1  opl3 clock; single clock domain.
- ic_n  in  1  asynchronous, active-low reset.
- sample_clk_en  in  1  one-clk pulse per output sample.
- reg_wr_valid  in  1  one-clk pulse; address/data qualify.
- reg_wr_address  in  8  register address.
- reg_wr_data  in  8  register data.
- force_timer_overflow  in  1  trick-SW-detection overflow request.
- status  out  8  {IRQ, FT1, FT2, 5'b0}.
- irq_n  out  1  registered, equals !status[7].

Behaviour:
- Reset (ic_n low, async):
  - Cleared to zero: presets, counters, prescalers, ST1/ST2, MASK1/MASK2, FT1/FT2.
  - Outputs: status=0x00, irq_n=1.
- Register decode (only when reg_wr_valid=1; all other addresses ignored):
  - 0x02: T1 preset <= data.
  - 0x03: T2 preset <= data.
  - 0x04 with data[7]=1: clear FT1 and FT2; data[6:0] ignored; MASK/ST bits unchanged.
  - 0x04 with data[7]=0: MASK1<=data[6], MASK2<=data[5], ST2<=data[1], ST1<=data[0].
- Prescalers:
  - Two free-running counters, mod TIMER1_DIV and mod TIMER2_DIV, advanced only on sample_clk_en.
  - tickN is asserted on the sample_clk_en where prescaler N == DIV-1; the prescaler wraps to 0 on that pulse.
  - Prescalers are not reset by start, so the first period after start may be short by up to DIV-1 samples.
- Timer counter N (8-bit):
  - Start: on an ST 0->1 transition (write cycle), counter <= preset, effective the next clk.
  - Rewriting ST=1 while already running is a no-op.
  - Running (ST=1) and tickN: if counter==0xFF, counter <= preset and an overflow event occurs; otherwise counter+1.
  - Stopped (ST=0): counter holds, ticks are ignored, and flags are retained.
  - A preset written while running is used at the next reload only; the current count is unaffected.
  - Preset 0xFF: overflow on every tick.
- Flags:
  - An overflow event sets FTN one clk after the tick, unless MASKN=1.
  - Setting MASKN does not clear an already-set FTN.
  - Same-cycle IRQ-reset write and overflow event: overflow wins, and FTN=1 afterwards.
  - Clearing MASKN does not retroactively set FTN.
- Status and IRQ:
  - status[7] = FT1|FT2 and status[6:5] = {FT1, FT2}, both combinational from the flag registers; status[4:0] = 0.
  - irq_n is registered: it goes low one clk after the first flag sets, and high one clk after both flags clear.
- Simultaneous start write and tick in the same cycle: the load takes priority and the tick is discarded.
- Reset asserted mid-count: everything returns to reset values immediately, and there is no pending overflow after release.

Optional Feature:
- Macro: OPL2_TIMERS_FORCE_OVERFLOW_EN.
- Defined:
  - force_timer_overflow=1 produces an overflow event on every running timer in that cycle.
  - Flag rules as above, masks honoured.
  - Counters reload their presets.
- Undefined: the port is present but ignored, with no logic generated.

Test Plan:
- Reset: hold ic_n=0 with random writes -> status=0x00, irq_n=1.
- Timer 1:
  - Stimulus: write 0x02=0xFE, then 0x04=0x01, with sample_clk_en every 10 clk.
  - Tick schedule: ticks fall on every 4th sample pulse.
  - Required response: counter goes 0xFE->0xFF->overflow, so FT1 sets on the 2nd tick.
  - Status: status=0xC0 and irq_n=0 one clk later.
- Mask and flag clear:
  - Write 0x04=0x41 with preset 0xFF -> counter keeps reloading but status stays 0x00.
  - Then write 0x04=0x80 after an unmasked FT2 overflow -> status returns to 0x00 and irq_n=1 the next clk.
- Timer 2 resolution:
  - Stimulus: preset 0x00 and ST2.
  - Required response: FT2 sets after exactly 256 ticks (4096 sample pulses ± prescaler phase); status=0xA0.
- Collision: IRQ-reset write in the same cycle as a T1 overflow -> FT1=1 afterwards. Also check that a preset change mid-count is used only after the next reload.
- With OPL2_TIMERS_FORCE_OVERFLOW_EN:
  - Stimulus: force_timer_overflow pulse with T1 running unmasked and T2 stopped.
  - Required response: status=0xC0 and T1 counter reloads its preset.
  - Without the macro: the same pulse leaves status=0x00.
